// File: rtl/disp_vramrd.sv
// rtl/disp_vramrd.sv - AXI read-burst generator for display scan-out (optional DISP_VRAMRD_RESPCHK_EN adds o_rd_err)
module disp_vramrd #(
   parameter int         C_DATA_WIDTH   = 64,
   parameter int         C_BURST_LEN    = 16,
   parameter int         C_MAX_OUTSTAND = 4,
   parameter logic [2:0] C_ADDR_HI      = 3'b001
) (
   input  logic        i_aclk,
   input  logic        i_arst,
   input  logic        i_vrstart,
   input  logic        i_dispon,
   input  logic [28:0] i_dispaddr,
   input  logic [11:0] i_hsize,
   input  logic [11:0] i_vsize,
   input  logic [15:0] i_stride,
   input  logic        i_buf_wready,
   output logic [31:0] o_araddr,
   output logic [7:0]  o_arlen,
   output logic [2:0]  o_arsize,
   output logic [1:0]  o_arburst,
   output logic        o_arvalid,
   input  logic        i_arready,
   input  logic        i_rvalid,
   input  logic        i_rlast,
   input  logic [1:0]  i_rresp,
   output logic        o_rready,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_start_ovr
`ifdef DISP_VRAMRD_RESPCHK_EN
   ,
   output logic        o_rd_err
`endif
);

   localparam int          BPB         = C_DATA_WIDTH / 8;
   localparam int          LOG2BPB     = $clog2(BPB);
   localparam logic [28:0] BURST_BYTES = 29'(C_BURST_LEN * BPB);
   localparam logic [12:0] BURST_BEATS = 13'(C_BURST_LEN);
   localparam logic [3:0]  MAX_OUTST   = 4'(C_MAX_OUTSTAND);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ADDR  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [28:0] r_line_base;
   logic [28:0] r_burst_addr;
   logic [15:0] r_stride;
   logic [12:0] r_lbeats;
   logic [12:0] r_beats_left;
   logic [11:0] r_lines_left;
   logic [31:0] r_araddr;
   logic [7:0]  r_arlen;
   logic [3:0]  r_outst;
   logic        r_abort;
   logic        r_rready;
   logic        r_frame_done;
   logic        r_start_ovr;

   logic        w_arvalid;
   logic        w_busy;
   logic        w_ar_hs;
   logic        w_r_dec;
   logic        w_issue_ok;
   logic        w_line_end;
   logic        w_last_burst;
   logic [3:0]  w_outst_nxt;
   logic [12:0] w_burst_len;
   logic [12:0] w_cur_len;
   logic [14:0] w_hbytes;
   logic [12:0] w_lbeats;
   logic        w_unused_rresp;

   // Line length in beats, rounded up to whole bus words
   assign w_hbytes   = {1'b0, i_hsize, 2'b00} + 15'(BPB - 1);
   assign w_lbeats   = 13'(w_hbytes >> LOG2BPB);

   // Burst in flight on AR and the next one to be built
   assign w_burst_len  = {5'd0, r_arlen} + 13'd1;
   assign w_cur_len    = (r_beats_left > BURST_BEATS) ? BURST_BEATS : r_beats_left;
   assign w_line_end   = (r_beats_left == w_burst_len);
   assign w_last_burst = w_line_end && (r_lines_left == 12'd1);

   assign w_ar_hs    = w_arvalid && i_arready;
   // An RLAST with nothing outstanding is stray and must not underflow the count
   assign w_r_dec    = i_rvalid && r_rready && i_rlast && (r_outst != 4'd0);
   assign w_issue_ok = i_buf_wready && (r_outst < MAX_OUTST);

   // Outstanding-burst count after this cycle's AR and R handshakes
   always_comb begin
      w_outst_nxt = r_outst;
      if (w_ar_hs && !w_r_dec) begin
         w_outst_nxt = r_outst + 4'd1;
      end else if (!w_ar_hs && w_r_dec) begin
         w_outst_nxt = r_outst - 4'd1;
      end
   end

   // FSM state register
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: issue bursts while enabled, then drain the returning data
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_vrstart && i_dispon) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!i_dispon) begin
               w_state_nxt = S_DRAIN;
            end else if (w_issue_ok) begin
               w_state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            if (i_arready) begin
               w_state_nxt = (w_last_burst || !i_dispon) ? S_DRAIN : S_WAIT;
            end
         end
         S_DRAIN: begin
            if (w_outst_nxt == 4'd0) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      w_arvalid = 1'b0;
      w_busy    = 1'b1;
      case (r_state)
         S_IDLE:  w_busy    = 1'b0;
         S_ADDR:  w_arvalid = 1'b1;
         default: w_busy    = 1'b1;
      endcase
   end

   // Outstanding-burst counter
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         r_outst <= 4'd0;
      end else begin
         r_outst <= w_outst_nxt;
      end
   end

   // Frame geometry latch, per-line/per-burst address walk and AR payload
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         r_line_base  <= 29'd0;
         r_burst_addr <= 29'd0;
         r_stride     <= 16'd0;
         r_lbeats     <= 13'd0;
         r_beats_left <= 13'd0;
         r_lines_left <= 12'd0;
         r_araddr     <= 32'd0;
         r_arlen      <= 8'd0;
      end else begin
         if (r_state == S_IDLE && i_vrstart && i_dispon) begin
            r_line_base  <= i_dispaddr;
            r_burst_addr <= i_dispaddr;
            r_stride     <= i_stride;
            r_lbeats     <= w_lbeats;
            r_beats_left <= w_lbeats;
            r_lines_left <= i_vsize;
         end
         // ARADDR/ARLEN are captured on entry to ADDR so they hold until ARREADY
         if (r_state == S_WAIT && i_dispon && w_issue_ok) begin
            r_araddr <= {C_ADDR_HI, r_burst_addr};
            r_arlen  <= 8'(w_cur_len - 13'd1);
         end
         if (w_ar_hs) begin
            if (w_line_end) begin
               r_lines_left <= r_lines_left - 12'd1;
               r_line_base  <= r_line_base + {13'd0, r_stride};
               r_burst_addr <= r_line_base + {13'd0, r_stride};
               r_beats_left <= r_lbeats;
            end else begin
               r_beats_left <= r_beats_left - w_burst_len;
               r_burst_addr <= r_burst_addr + BURST_BYTES;
            end
         end
      end
   end

   // Status pulses, abort tracking and RREADY
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         r_abort      <= 1'b0;
         r_rready     <= 1'b0;
         r_frame_done <= 1'b0;
         r_start_ovr  <= 1'b0;
      end else begin
         r_rready    <= 1'b1;
         r_start_ovr <= i_vrstart && w_busy;
         // A frame cut short by DISPON never reports completion
         if (r_state == S_IDLE && i_vrstart && i_dispon) begin
            r_abort <= 1'b0;
         end else if (w_busy && !i_dispon) begin
            r_abort <= 1'b1;
         end
         r_frame_done <= (r_state == S_DRAIN) && (w_outst_nxt == 4'd0) &&
                         !r_abort && i_dispon;
      end
   end

`ifdef DISP_VRAMRD_RESPCHK_EN
   logic r_rd_err;

   // Sticky SLVERR/DECERR flag, cleared when the next frame is accepted
   always_ff @(posedge i_aclk) begin
      if (i_arst) begin
         r_rd_err <= 1'b0;
      end else if (r_state == S_IDLE && i_vrstart && i_dispon) begin
         r_rd_err <= 1'b0;
      end else if (i_rvalid && r_rready && i_rresp[1]) begin
         r_rd_err <= 1'b1;
      end
   end

   assign o_rd_err       = r_rd_err;
   assign w_unused_rresp = i_rresp[0];
`else
   assign w_unused_rresp = ^i_rresp;
`endif

   assign o_araddr     = r_araddr;
   assign o_arlen      = r_arlen;
   assign o_arsize     = 3'(LOG2BPB);
   assign o_arburst    = 2'b01;
   assign o_arvalid    = w_arvalid;
   assign o_rready     = r_rready;
   assign o_busy       = w_busy;
   assign o_frame_done = r_frame_done;
   assign o_start_ovr  = r_start_ovr;

endmodule

// File: tb/tb_disp_vramrd.sv
// tb/tb_disp_vramrd.sv - directed self-checking bench for disp_vramrd (DISP_VRAMRD_RESPCHK_EN optional)
module tb_disp_vramrd;

   logic        clk = 1'b0;
   logic        i_arst = 1'b1;
   logic        i_vrstart = 1'b0;
   logic        i_dispon = 1'b0;
   logic [28:0] i_dispaddr = 29'd0;
   logic [11:0] i_hsize = 12'd1;
   logic [11:0] i_vsize = 12'd1;
   logic [15:0] i_stride = 16'd0;
   logic        i_buf_wready = 1'b1;
   logic        i_arready = 1'b0;
   logic        i_rvalid = 1'b0;
   logic        i_rlast = 1'b0;
   logic [1:0]  i_rresp = 2'b00;
   logic [31:0] o_araddr;
   logic [7:0]  o_arlen;
   logic [2:0]  o_arsize;
   logic [1:0]  o_arburst;
   logic        o_arvalid;
   logic        o_rready;
   logic        o_busy;
   logic        o_frame_done;
   logic        o_start_ovr;
`ifdef DISP_VRAMRD_RESPCHK_EN
   logic        o_rd_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_ar = 0;
   int n_fd = 0;
   int n_ovr = 0;
   int r_allow = 100000;
   int err_beats = 0;
   bit ar_en = 1'b1;
   int q[$];
   int bc = 0;
   logic [31:0] ar_addr [0:255];
   logic [7:0]  ar_len  [0:255];

   disp_vramrd dut (
      .i_aclk(clk), .i_arst(i_arst), .i_vrstart(i_vrstart), .i_dispon(i_dispon),
      .i_dispaddr(i_dispaddr), .i_hsize(i_hsize), .i_vsize(i_vsize), .i_stride(i_stride),
      .i_buf_wready(i_buf_wready), .o_araddr(o_araddr), .o_arlen(o_arlen),
      .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arvalid(o_arvalid),
      .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rresp(i_rresp),
      .o_rready(o_rready), .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_start_ovr(o_start_ovr)
`ifdef DISP_VRAMRD_RESPCHK_EN
      , .o_rd_err(o_rd_err)
`endif
   );

   always #5 clk = ~clk;

   // AXI slave model: drives ARREADY/R at the falling edge, logs handshakes due at the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         if (o_frame_done) n_fd++;
         if (o_start_ovr) n_ovr++;
         if (i_arst) begin
            q.delete();
            bc = 0;
            i_rvalid = 1'b0;
            i_rlast = 1'b0;
            i_rresp = 2'b00;
         end else begin
            if (r_allow > 0 && q.size() > 0 && o_rready) begin
               i_rvalid = 1'b1;
               bc++;
               i_rlast = (bc == q[0]);
               if (err_beats > 0) begin
                  i_rresp = 2'b10;
                  err_beats--;
               end else begin
                  i_rresp = 2'b00;
               end
               if (i_rlast) begin
                  void'(q.pop_front());
                  bc = 0;
                  r_allow--;
               end
            end else begin
               i_rvalid = 1'b0;
               i_rlast = 1'b0;
               i_rresp = 2'b00;
            end
         end
         i_arready = ar_en;
         if (o_arvalid && i_arready) begin
            if (n_ar < 256) begin
               ar_addr[n_ar] = o_araddr;
               ar_len[n_ar] = o_arlen;
            end
            n_ar++;
            q.push_back(int'(o_arlen) + 1);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_frame(input logic [28:0] a, input logic [11:0] h,
                              input logic [11:0] v, input logic [15:0] s);
      i_dispaddr = a;
      i_hsize = h;
      i_vsize = v;
      i_stride = s;
      i_vrstart = 1'b1;
      tick();
      i_vrstart = 1'b0;
   endtask

   task automatic wait_fd(input int target);
      for (int k = 0; k < 4000 && n_fd < target; k++) tick();
      check("frame_done_wait", n_fd, target);
   endtask

   task automatic wait_ar(input int target);
      for (int k = 0; k < 4000 && n_ar < target; k++) tick();
      check("ar_wait", n_ar, target);
   endtask

   initial begin
      int b;
      int fd0;
      int ovr0;

      // Reset state
      ticks(3);
      check("rst_arvalid", o_arvalid, 0);
      check("rst_araddr", o_araddr, 0);
      check("rst_arlen", o_arlen, 0);
      check("rst_busy", o_busy, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_start_ovr", o_start_ovr, 0);
      check("rst_rready", o_rready, 0);
      i_arst = 1'b0;
      tick();
      check("rready_after_rst", o_rready, 1);
      check("arsize", o_arsize, 3);
      check("arburst", o_arburst, 1);

      // VRSTART with DISPON low is ignored
      b = n_ar;
      start_frame(29'h0010_0000, 12'd640, 12'd1, 16'd0);
      ticks(5);
      check("dispon0_busy", o_busy, 0);
      check("dispon0_ar", n_ar - b, 0);

      // Two 640-pixel lines: 20 full bursts per line
      i_dispon = 1'b1;
      b = n_ar;
      start_frame(29'h0010_0000, 12'd640, 12'd2, 16'd2560);
      wait_fd(1);
      check("t1_busy_clear", o_busy, 0);
      check("t1_ar_count", n_ar - b, 40);
      for (int i = 0; i < 40; i++) begin
         check("t1_addr", ar_addr[b + i], 32'h2010_0000 + (i / 20) * 32'h0A00 + (i % 20) * 32'h80);
         check("t1_len", {24'd0, ar_len[b + i]}, 32'd15);
      end
      ticks(3);
      check("t1_single_fd", n_fd, 1);

      // Short line: 50 beats -> 16,16,16,2
      b = n_ar;
      start_frame(29'h0020_0000, 12'd100, 12'd1, 16'd0);
      wait_fd(2);
      check("t2_ar_count", n_ar - b, 4);
      check("t2_addr0", ar_addr[b], 32'h2020_0000);
      check("t2_addr3", ar_addr[b + 3], 32'h2020_0180);
      check("t2_len2", {24'd0, ar_len[b + 2]}, 32'd15);
      check("t2_len3", {24'd0, ar_len[b + 3]}, 32'd1);

      // Outstanding limit: no data returned
      r_allow = 0;
      b = n_ar;
      start_frame(29'h0030_0000, 12'd640, 12'd1, 16'd0);
      ticks(60);
      check("t3_ar_limit", n_ar - b, 4);
      check("t3_arvalid_low", o_arvalid, 0);
      check("t3_busy", o_busy, 1);
      r_allow = 1;
      ticks(60);
      check("t3_one_more", n_ar - b, 5);
      check("t3_arvalid_low2", o_arvalid, 0);
      r_allow = 100000;
      wait_fd(3);
      check("t3_ar_total", n_ar - b, 20);

      // BUF_WREADY low blocks issue; ARREADY low holds the request stable
      i_buf_wready = 1'b0;
      b = n_ar;
      start_frame(29'h0040_0000, 12'd100, 12'd1, 16'd0);
      ticks(30);
      check("t4_no_ar", n_ar - b, 0);
      check("t4_no_arvalid", o_arvalid, 0);
      ar_en = 1'b0;
      i_buf_wready = 1'b1;
      tick();
      check("t4_arvalid_up", o_arvalid, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_hold_addr", o_araddr, 32'h2040_0000);
         check("t4_hold_len", {24'd0, o_arlen}, 32'd15);
      end
      ar_en = 1'b1;
      wait_fd(4);
      check("t4_ar_count", n_ar - b, 4);
      check("t4_first_addr", ar_addr[b], 32'h2040_0000);

      // DISPON falls after 3 ARs; VRSTART while busy
      r_allow = 0;
      fd0 = n_fd;
      ovr0 = n_ovr;
      b = n_ar;
      start_frame(29'h0050_0000, 12'd640, 12'd1, 16'd0);
      wait_ar(b + 3);
      i_dispon = 1'b0;
      ticks(30);
      check("t5_no_4th", n_ar - b, 3);
      check("t5_busy_held", o_busy, 1);
      i_vrstart = 1'b1;
      tick();
      i_vrstart = 1'b0;
      ticks(2);
      check("t5_start_ovr", n_ovr - ovr0, 1);
      r_allow = 3;
      ticks(60);
      check("t5_busy_clear", o_busy, 0);
      check("t5_no_fd", n_fd - fd0, 0);
      check("t5_not_restarted", n_ar - b, 3);
      r_allow = 100000;
      i_dispon = 1'b1;

`ifdef DISP_VRAMRD_RESPCHK_EN
      // Error response is sticky until the next accepted frame
      err_beats = 1;
      fd0 = n_fd;
      start_frame(29'h0070_0000, 12'd100, 12'd1, 16'd0);
      wait_fd(fd0 + 1);
      check("t6_rd_err_set", o_rd_err, 1);
      ticks(5);
      check("t6_rd_err_sticky", o_rd_err, 1);
      start_frame(29'h0070_0000, 12'd100, 12'd1, 16'd0);
      check("t6_rd_err_clear", o_rd_err, 0);
      wait_fd(fd0 + 2);
      check("t6_rd_err_stays0", o_rd_err, 0);
`endif

      // Reset in the middle of a frame
      r_allow = 0;
      start_frame(29'h0060_0000, 12'd640, 12'd1, 16'd0);
      ticks(20);
      i_arst = 1'b1;
      tick();
      check("arst_arvalid", o_arvalid, 0);
      check("arst_araddr", o_araddr, 0);
      check("arst_arlen", o_arlen, 0);
      check("arst_busy", o_busy, 0);
      check("arst_fd", o_frame_done, 0);
      check("arst_rready", o_rready, 0);
      i_arst = 1'b0;
      r_allow = 100000;
      tick();
      check("arst_rready_back", o_rready, 1);
      fd0 = n_fd;
      b = n_ar;
      start_frame(29'h0080_0000, 12'd100, 12'd1, 16'd0);
      wait_fd(fd0 + 1);
      check("arst_clean_frame", n_ar - b, 4);
      check("arst_clean_addr", ar_addr[b + 1], 32'h2080_0080);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
